demux1to4_8bit_reg: RTL and testbench

Registered 1-to-4 distributor for 8-bit values, the write-side counterpart of the 4:1 8-bit select path. It accepts a byte plus a 2-bit channel select, or an internal auto-incrementing pointer, and latches the byte into one of four holding registers. It tracks per-channel valid flags and flags overwrites. Its four outputs feed the game's 4-lane display and score paths, where they are read back through the 4:1 selector.

---
 rtl/demux1to4_8bit_reg_if.sv | 27 ++
 rtl/demux1to4_8bit_reg.sv | 62 ++++++
 tb/tb_demux1to4_8bit_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/demux1to4_8bit_reg_if.sv
// Bus bundle for the registered 1-to-4 byte distributor: write-side controls
// from the writer (master) and the four holding registers plus status from the block (slave).
interface demux1to4_8bit_reg_if;
    logic [1:0] S;
    logic [7:0] I;
    logic       wr_en;
    logic       auto_inc;
    logic       clr;
    logic [7:0] O0;
    logic [7:0] O1;
    logic [7:0] O2;
    logic [7:0] O3;
    logic [3:0] V;
    logic [1:0] wr_ptr;
    logic       full;
    logic       ovr;

    modport master (
        output S, I, wr_en, auto_inc, clr,
        input  O0, O1, O2, O3, V, wr_ptr, full, ovr
    );

    modport slave (
        input  S, I, wr_en, auto_inc, clr,
        output O0, O1, O2, O3, V, wr_ptr, full, ovr
    );
endinterface

// File: rtl/demux1to4_8bit_reg.sv
// Registered 1-to-4 byte distributor with per-channel valid flags, auto-increment pointer and
// overwrite pulse. Define DEMUX_OVR_PROTECT_EN to drop writes that target an already-valid channel.
module demux1to4_8bit_reg (
    input  logic                       clk,
    input  logic                       rst_n,
    demux1to4_8bit_reg_if.slave        bus
);

    logic [7:0] r_data [4];
    logic [3:0] r_valid;
    logic [1:0] r_ptr;
    logic       r_ovr;

    logic [1:0] w_target;
    logic       w_hit;
    logic       w_data_we;

    assign w_target = bus.auto_inc ? r_ptr : bus.S;
    assign w_hit    = r_valid[w_target];

`ifdef DEMUX_OVR_PROTECT_EN
    // Protected build keeps the first value a channel received until the next clear.
    assign w_data_we = ~w_hit;
`else
    assign w_data_we = 1'b1;
`endif

    // NOTE: holding registers are reset too, because consumers read them right after reset and must see 8'h00.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '{default: 8'h00};
            r_valid <= 4'b0000;
            r_ptr   <= 2'b00;
            r_ovr   <= 1'b0;
        end else if (bus.clr) begin
            r_valid <= 4'b0000;
            r_ptr   <= 2'b00;
            r_ovr   <= 1'b0;
        end else if (bus.wr_en) begin
            if (w_data_we) begin
                r_data[w_target] <= bus.I;
            end
            r_valid[w_target] <= 1'b1;
            if (bus.auto_inc) begin
                r_ptr <= r_ptr + 2'd1;
            end
            r_ovr <= w_hit;
        end else begin
            r_ovr <= 1'b0;
        end
    end

    assign bus.O0     = r_data[0];
    assign bus.O1     = r_data[1];
    assign bus.O2     = r_data[2];
    assign bus.O3     = r_data[3];
    assign bus.V      = r_valid;
    assign bus.wr_ptr = r_ptr;
    assign bus.ovr    = r_ovr;
    assign bus.full   = &r_valid;

endmodule

// File: tb/tb_demux1to4_8bit_reg.sv
// Directed self-checking bench for demux1to4_8bit_reg; expected values are hand-computed,
// with the overwrite-protected variant selected by DEMUX_OVR_PROTECT_EN.
module tb_demux1to4_8bit_reg;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux1to4_8bit_reg_if bus ();

    demux1to4_8bit_reg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic ai, input logic [1:0] s,
                         input logic [7:0] d, input logic c);
        bus.wr_en    = en;
        bus.auto_inc = ai;
        bus.S        = s;
        bus.I        = d;
        bus.clr      = c;
    endtask

    logic [7:0] exp_o2_ovr;
    logic [7:0] exp_o0_ovr1;
    logic [7:0] exp_o0_ovr2;

    initial begin
        total = 0;
        bad   = 0;
`ifdef DEMUX_OVR_PROTECT_EN
        exp_o2_ovr  = 8'hA5;
        exp_o0_ovr1 = 8'h01;
        exp_o0_ovr2 = 8'h01;
`else
        exp_o2_ovr  = 8'h5A;
        exp_o0_ovr1 = 8'hE0;
        exp_o0_ovr2 = 8'hF0;
`endif

        // Reset held two cycles with a write pending
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 8'hFF, 1'b0);
        tick();
        tick();
        check("rst_o0", bus.O0, 8'h00);
        check("rst_o1", bus.O1, 8'h00);
        check("rst_o2", bus.O2, 8'h00);
        check("rst_o3", bus.O3, 8'h00);
        check("rst_v", {4'h0, bus.V}, 8'h00);
        check("rst_ptr", {6'h0, bus.wr_ptr}, 8'h00);
        check("rst_full", {7'h0, bus.full}, 8'h00);
        check("rst_ovr", {7'h0, bus.ovr}, 8'h00);

        // Auto fill
        #1 rst_n = 1'b1;
        drive(1'b1, 1'b1, 2'd3, 8'h11, 1'b0);
        tick();
        check("fill1_o0", bus.O0, 8'h11);
        check("fill1_v", {4'h0, bus.V}, 8'h01);
        check("fill1_ptr", {6'h0, bus.wr_ptr}, 8'h01);
        bus.I = 8'h22;
        tick();
        bus.I = 8'h33;
        tick();
        check("fill3_full", {7'h0, bus.full}, 8'h00);
        bus.I = 8'h44;
        tick();
        check("fill_o0", bus.O0, 8'h11);
        check("fill_o1", bus.O1, 8'h22);
        check("fill_o2", bus.O2, 8'h33);
        check("fill_o3", bus.O3, 8'h44);
        check("fill_v", {4'h0, bus.V}, 8'h0F);
        check("fill_full", {7'h0, bus.full}, 8'h01);
        check("fill_ptr_wrap", {6'h0, bus.wr_ptr}, 8'h00);
        check("fill_ovr", {7'h0, bus.ovr}, 8'h00);

        // Clear wins over a coincident write
        drive(1'b1, 1'b0, 2'd1, 8'h77, 1'b1);
        tick();
        check("clr_v", {4'h0, bus.V}, 8'h00);
        check("clr_ptr", {6'h0, bus.wr_ptr}, 8'h00);
        check("clr_o1", bus.O1, 8'h22);
        check("clr_ovr", {7'h0, bus.ovr}, 8'h00);
        check("clr_full", {7'h0, bus.full}, 8'h00);

        // Explicit write
        drive(1'b1, 1'b0, 2'd2, 8'hA5, 1'b0);
        tick();
        check("exp_o2", bus.O2, 8'hA5);
        check("exp_v", {4'h0, bus.V}, 8'h04);
        check("exp_ptr", {6'h0, bus.wr_ptr}, 8'h00);
        check("exp_ovr", {7'h0, bus.ovr}, 8'h00);

        // Overwrite pulses ovr for one cycle
        bus.I = 8'h5A;
        tick();
        check("ovr_pulse", {7'h0, bus.ovr}, 8'h01);
        check("ovr_o2", bus.O2, exp_o2_ovr);
        check("ovr_o1_kept", bus.O1, 8'h22);
        bus.wr_en = 1'b0;
        tick();
        check("ovr_drop", {7'h0, bus.ovr}, 8'h00);

        // Back-to-back overwrites keep ovr high
        drive(1'b1, 1'b0, 2'd2, 8'h5A, 1'b0);
        tick();
        tick();
        check("ovr_b2b", {7'h0, bus.ovr}, 8'h01);
        bus.wr_en = 1'b0;
        tick();
        check("ovr_b2b_drop", {7'h0, bus.ovr}, 8'h00);

        // Wrap and mixed writes
        drive(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        tick();
        drive(1'b1, 1'b1, 2'd2, 8'h01, 1'b0);
        tick();
        bus.I = 8'h02;
        tick();
        bus.I = 8'h03;
        tick();
        check("mix_ptr3", {6'h0, bus.wr_ptr}, 8'h03);
        check("mix_o2", bus.O2, 8'h03);
        bus.I = 8'h04;
        tick();
        check("mix_ptr_wrap", {6'h0, bus.wr_ptr}, 8'h00);
        check("mix_o3", bus.O3, 8'h04);
        check("mix_full", {7'h0, bus.full}, 8'h01);
        check("mix_ovr0", {7'h0, bus.ovr}, 8'h00);
        drive(1'b1, 1'b0, 2'd0, 8'hE0, 1'b0);
        tick();
        check("mix_exp_ptr", {6'h0, bus.wr_ptr}, 8'h00);
        check("mix_exp_ovr", {7'h0, bus.ovr}, 8'h01);
        check("mix_exp_o0", bus.O0, exp_o0_ovr1);
        drive(1'b1, 1'b1, 2'd3, 8'hF0, 1'b0);
        tick();
        check("mix_auto_o0", bus.O0, exp_o0_ovr2);
        check("mix_auto_ovr", {7'h0, bus.ovr}, 8'h01);
        check("mix_auto_ptr", {6'h0, bus.wr_ptr}, 8'h01);
        check("mix_auto_o3", bus.O3, 8'h04);

        // Reset mid-sequence discards the pending write
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 2'd0, 8'h99, 1'b0);
        tick();
        check("mrst_o0", bus.O0, 8'h00);
        check("mrst_o3", bus.O3, 8'h00);
        check("mrst_v", {4'h0, bus.V}, 8'h00);
        check("mrst_ptr", {6'h0, bus.wr_ptr}, 8'h00);
        check("mrst_ovr", {7'h0, bus.ovr}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
